// File: rtl/demux10_router.sv
// ---------------------------------------------------------------------------
// demux10_router
//
// Purpose
//   Routes one input beat per cycle to one of ten registered output
//   channels chosen by S.  Each channel is a single-entry output register
//   with its own valid/ready handshake, so all ten channels drain
//   independently.  Beats whose select is 10..15 are accepted and thrown
//   away, and DROP pulses for one cycle to report this.
//
// Handshake rule, used on the input side and on every output channel:
//   A transfer happens on a rising edge where valid and ready are both 1.
//   A producer holds its data stable while valid=1 and ready=0.  Ready never
//   depends on valid.
//
// Ports
//   clk       : clock; all state changes on the rising edge
//   rst_n     : asynchronous active-low reset
//   S[3:0]    : destination select (0..9 = channel, 10..15 = discard)
//   I[DW-1:0] : input data
//   I_VALID   : input beat present
//   I_READY   : router takes the beat this cycle (combinational from S, O_READY)
//   Z0..Z9    : registered per-channel output data
//   O_VALID   : bit k set = Zk holds an unconsumed beat
//   O_READY   : bit k set = channel k consumer takes Zk this cycle
//   DROP      : one-cycle pulse on the cycle after a discarded beat
//   DROP_CNT  : (only with DEMUX10_DROP_CNT_EN) saturating count of
//               discarded beats, cleared only by reset
//
// Build option
//   `define DEMUX10_DROP_CNT_EN adds the DROP_CNT port and its counter.
// ---------------------------------------------------------------------------
module demux10_router #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    S,
    input  logic [DW-1:0] I,
    input  logic          I_VALID,
    output logic          I_READY,
    output logic [DW-1:0] Z0,
    output logic [DW-1:0] Z1,
    output logic [DW-1:0] Z2,
    output logic [DW-1:0] Z3,
    output logic [DW-1:0] Z4,
    output logic [DW-1:0] Z5,
    output logic [DW-1:0] Z6,
    output logic [DW-1:0] Z7,
    output logic [DW-1:0] Z8,
    output logic [DW-1:0] Z9,
    output logic [9:0]    O_VALID,
    input  logic [9:0]    O_READY,
    output logic          DROP
`ifdef DEMUX10_DROP_CNT_EN
    ,
    output logic [7:0]    DROP_CNT
`endif
);

    localparam int NCH = 10;

    logic [DW-1:0] r_z [NCH];
    logic [9:0]    r_ovalid;
    logic          r_drop;

    logic [15:0]   w_ov_ext;
    logic [15:0]   w_ordy_ext;
    logic          w_sel_in_range;
    logic          w_ready;
    logic          w_accept;
    logic [9:0]    w_load;

    // Zero-extend the per-channel vectors to 16 entries so that any 4-bit
    // select indexes a defined bit; the upper entries are never consulted
    // because out-of-range selects are always ready.
    assign w_ov_ext       = {6'd0, r_ovalid};
    assign w_ordy_ext     = {6'd0, O_READY};
    assign w_sel_in_range = (S <= 4'd9);

    // A channel can take a new beat when it is empty or is being emptied
    // on this same edge; discards are always taken.
    assign w_ready  = !w_sel_in_range || !w_ov_ext[S] || w_ordy_ext[S];
    assign w_accept = I_VALID && w_ready;

    for (genvar k = 0; k < NCH; k++) begin : g_load
        assign w_load[k] = w_accept && (S == 4'(k));
    end

    // Per-channel output register.  A load wins over a drain on the same
    // edge, which keeps the channel valid with the new data and gives one
    // beat per cycle per channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovalid <= '0;
            for (int k = 0; k < NCH; k++) begin
                r_z[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (w_load[k]) begin
                    r_z[k]      <= I;
                    r_ovalid[k] <= 1'b1;
                end else if (O_READY[k]) begin
                    r_ovalid[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop <= 1'b0;
        end else begin
            r_drop <= w_accept && !w_sel_in_range;
        end
    end

`ifdef DEMUX10_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_accept && !w_sel_in_range && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign DROP_CNT = r_drop_cnt;
`endif

    assign I_READY = w_ready;
    assign O_VALID = r_ovalid;
    assign DROP    = r_drop;

    assign Z0 = r_z[0];
    assign Z1 = r_z[1];
    assign Z2 = r_z[2];
    assign Z3 = r_z[3];
    assign Z4 = r_z[4];
    assign Z5 = r_z[5];
    assign Z6 = r_z[6];
    assign Z7 = r_z[7];
    assign Z8 = r_z[8];
    assign Z9 = r_z[9];

endmodule

// File: tb/tb_demux10_router.sv
// ---------------------------------------------------------------------------
// tb_demux10_router
//
// Bench for demux10_router.  A queue-per-channel model tracks which beats
// each channel is holding; a compare process checks every output on each
// falling edge while reset is released, and directed sections pin the model
// with hand-computed literal values.
// ---------------------------------------------------------------------------
module tb_demux10_router;

    localparam int DW  = 8;
    localparam int NCH = 10;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [3:0]    s;
    logic [DW-1:0] din;
    logic          i_valid;
    logic          i_ready;
    logic [DW-1:0] z0, z1, z2, z3, z4, z5, z6, z7, z8, z9;
    logic [9:0]    o_valid;
    logic [9:0]    o_ready;
    logic          drop;
`ifdef DEMUX10_DROP_CNT_EN
    logic [7:0]    drop_cnt;
`endif

    logic [DW-1:0] z_arr [NCH];
    assign z_arr[0] = z0;
    assign z_arr[1] = z1;
    assign z_arr[2] = z2;
    assign z_arr[3] = z3;
    assign z_arr[4] = z4;
    assign z_arr[5] = z5;
    assign z_arr[6] = z6;
    assign z_arr[7] = z7;
    assign z_arr[8] = z8;
    assign z_arr[9] = z9;

    demux10_router #(.DW(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .S       (s),
        .I       (din),
        .I_VALID (i_valid),
        .I_READY (i_ready),
        .Z0      (z0),
        .Z1      (z1),
        .Z2      (z2),
        .Z3      (z3),
        .Z4      (z4),
        .Z5      (z5),
        .Z6      (z6),
        .Z7      (z7),
        .Z8      (z8),
        .Z9      (z9),
        .O_VALID (o_valid),
        .O_READY (o_ready),
        .DROP    (drop)
`ifdef DEMUX10_DROP_CNT_EN
        ,
        .DROP_CNT(drop_cnt)
`endif
    );

    // ---------------- scoreboard counters ----------------
    int n_vec;
    int n_bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each channel is a queue of beats the consumer has yet to see; the
    // router holds at most one per channel, so the head is what Zk shows.
    logic [DW-1:0] exp_q [NCH][$];
    logic          exp_drop;
    int            exp_drop_cnt;
    int            sent_cnt [NCH];
    int            recv_cnt [NCH];

    function automatic logic model_ready(input logic [3:0] sel, input logic [9:0] ordy);
        if (sel >= 4'd10) return 1'b1;
        return (exp_q[sel].size() == 0) || ordy[sel];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) exp_q[k].delete();
            exp_drop     = 1'b0;
            exp_drop_cnt = 0;
        end else begin
            logic acc;
            acc = i_valid && model_ready(s, o_ready);
            for (int k = 0; k < NCH; k++) begin
                if (exp_q[k].size() > 0 && o_ready[k]) begin
                    void'(exp_q[k].pop_front());
                    recv_cnt[k]++;
                end
            end
            exp_drop = acc && (s >= 4'd10);
            if (acc && s < 4'd10) begin
                exp_q[s].push_back(din);
                sent_cnt[s]++;
            end
            if (exp_drop && exp_drop_cnt < 255) exp_drop_cnt++;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            logic [9:0] ev;
            ev = '0;
            for (int k = 0; k < NCH; k++) ev[k] = (exp_q[k].size() > 0);
            chk("cmp_i_ready", {31'd0, i_ready}, {31'd0, model_ready(s, o_ready)});
            chk("cmp_o_valid", {22'd0, o_valid}, {22'd0, ev});
            chk("cmp_drop", {31'd0, drop}, {31'd0, exp_drop});
            for (int k = 0; k < NCH; k++) begin
                if (exp_q[k].size() > 0)
                    chk($sformatf("cmp_z%0d", k), {24'd0, z_arr[k]}, {24'd0, exp_q[k][0]});
            end
`ifdef DEMUX10_DROP_CNT_EN
            chk("cmp_drop_cnt", {24'd0, drop_cnt}, exp_drop_cnt);
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [3:0] sel, input logic [DW-1:0] d,
                         input logic v, input logic [9:0] ordy);
        s       = sel;
        din     = d;
        i_valid = v;
        o_ready = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        n_vec = 0;
        n_bad = 0;
        for (int k = 0; k < NCH; k++) begin
            sent_cnt[k] = 0;
            recv_cnt[k] = 0;
        end
        drive(4'd0, 8'h00, 1'b0, 10'h000);
        rst_n = 1'b0;
        #2;
        // reset state while rst_n is low
        chk("rst_o_valid", {22'd0, o_valid}, 32'h0);
        chk("rst_drop", {31'd0, drop}, 32'h0);
        chk("rst_z3", {24'd0, z3}, 32'h0);
        do_reset();
        step();

        // single beat into channel 3, consumer stalled
        drive(4'd3, 8'hA5, 1'b1, 10'h000);
        #1 chk("ch3_load_ready", {31'd0, i_ready}, 32'h1);
        step();
        drive(4'd4, 8'h00, 1'b0, 10'h000);
        #1;
        chk("ch3_o_valid", {22'd0, o_valid}, 32'h008);
        chk("ch3_z3", {24'd0, z3}, 32'hA5);
        chk("ch3_ready_s4", {31'd0, i_ready}, 32'h1);
        s = 4'd3;
        #1 chk("ch3_ready_s3", {31'd0, i_ready}, 32'h0);
        step();
        chk("ch3_held_z3", {24'd0, z3}, 32'hA5);

        // same-edge drain and reload of channel 3
        drive(4'd3, 8'h5A, 1'b1, 10'h008);
        #1 chk("ch3_thru_ready", {31'd0, i_ready}, 32'h1);
        step();
        drive(4'd0, 8'h00, 1'b0, 10'h000);
        #1;
        chk("ch3_thru_z3", {24'd0, z3}, 32'h5A);
        chk("ch3_thru_valid", {22'd0, o_valid}, 32'h008);

        // discard with S=12 while channel 3 is still full
        drive(4'd12, 8'h77, 1'b1, 10'h000);
        #1 chk("drop_ready", {31'd0, i_ready}, 32'h1);
        step();
        drive(4'd0, 8'h00, 1'b0, 10'h000);
        #1;
        chk("drop_pulse", {31'd0, drop}, 32'h1);
        chk("drop_o_valid", {22'd0, o_valid}, 32'h008);
        step();
        chk("drop_pulse_end", {31'd0, drop}, 32'h0);
        drive(4'd0, 8'h00, 1'b0, 10'h008);
        step();
        drive(4'd0, 8'h00, 1'b0, 10'h000);
        #1 chk("ch3_drained", {22'd0, o_valid}, 32'h0);

`ifdef DEMUX10_DROP_CNT_EN
        for (int n = 0; n < 300; n++) begin
            drive(4'(10 + (n % 6)), 8'(n), 1'b1, 10'h000);
            step();
        end
        drive(4'd0, 8'h00, 1'b0, 10'h000);
        #1 chk("drop_cnt_sat", {24'd0, drop_cnt}, 32'd255);
`endif

        // fill all ten channels, then drain together
        for (int k = 0; k < NCH; k++) begin
            drive(4'(k), 8'(k), 1'b1, 10'h000);
            step();
        end
        drive(4'd0, 8'h00, 1'b0, 10'h000);
        #1;
        chk("fill_o_valid", {22'd0, o_valid}, 32'h3FF);
        for (int k = 0; k < NCH; k++)
            chk($sformatf("fill_z%0d", k), {24'd0, z_arr[k]}, k);
        drive(4'd0, 8'h00, 1'b0, 10'h3FF);
        step();
        drive(4'd0, 8'h00, 1'b0, 10'h000);
        #1 chk("drain_all", {22'd0, o_valid}, 32'h0);

        // asynchronous reset between edges with channel 7 full
        drive(4'd7, 8'hC3, 1'b1, 10'h000);
        step();
        drive(4'd0, 8'h00, 1'b0, 10'h000);
        #1 chk("ch7_loaded", {22'd0, o_valid}, 32'h080);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {22'd0, o_valid}, 32'h0);
        chk("async_rst_z7", {24'd0, z7}, 32'h0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        // acceptance resumes on the first edge after release
        drive(4'd2, 8'h11, 1'b1, 10'h000);
        step();
        drive(4'd0, 8'h00, 1'b0, 10'h000);
        #1;
        chk("post_rst_valid", {22'd0, o_valid}, 32'h004);
        chk("post_rst_z2", {24'd0, z2}, 32'h11);
        drive(4'd0, 8'h00, 1'b0, 10'h004);
        step();
        for (int k = 0; k < NCH; k++) begin
            sent_cnt[k] = 0;
            recv_cnt[k] = 0;
        end

        // random traffic, mostly legal selects
        for (int n = 0; n < 10000; n++) begin
            logic [3:0] rs;
            rs = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                             : 4'($urandom_range(0, 9));
            drive(rs, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                  10'($urandom_range(0, 1023)));
            step();
        end
        drive(4'd0, 8'h00, 1'b0, 10'h3FF);
        repeat (2) step();
        chk("final_o_valid", {22'd0, o_valid}, 32'h0);
        for (int k = 0; k < NCH; k++)
            chk($sformatf("final_count_ch%0d", k), recv_cnt[k], sent_cnt[k]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
